// File: rtl/rr_stream_mux_pkg.sv
// Shared types for the round-robin stream multiplexer.
// Arbitration mode encoding matches the rr_en port.
package rr_stream_mux_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

endpackage

// File: rtl/rr_stream_mux_rr_pick.sv
// Combinational arbiter: rotating or fixed-priority request picker.
// Ports: req, ptr, rr_en in; gnt (one-hot), gnt_idx, any out.
module rr_pick
  import rr_stream_mux_pkg::*;
#(
  parameter int N_CH = 4,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  input  logic            rr_en,
  output logic [N_CH-1:0] gnt,
  output logic [CH_W-1:0] gnt_idx,
  output logic            any
);

  arb_mode_e         mode;
  logic [CH_W-1:0]   base;
  logic [2*N_CH-1:0] dbl;
  logic [N_CH-1:0]   rot;
  logic [CH_W-1:0]   off;
  logic [CH_W:0]     sum;

  assign mode = arb_mode_e'(rr_en);

  always_comb begin
    base = (mode == ARB_RR) ? ptr : '0;
    // Rotate so that bit 0 is the channel at the search start.
    dbl  = {req, req} >> base;
    rot  = dbl[N_CH-1:0];
    any  = |req;
    off  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rot[i]) off = CH_W'(i);
    end
    // Undo the rotation, wrapping modulo N_CH.
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= (CH_W+1)'(N_CH)) begin
      sum = sum - (CH_W+1)'(N_CH);
    end
    gnt_idx = sum[CH_W-1:0];
    gnt     = any ? (N_CH'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream mux with a registered output stage.
// Ports: clk, rst, rr_en, in_valid/in_data/in_ready, out_valid/out_data/out_ch/out_ready.
module rr_stream_mux
  import rr_stream_mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 8,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rr_en,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH*W-1:0] in_data,
  output logic [N_CH-1:0]   in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [CH_W-1:0]   out_ch,
  input  logic              out_ready
);

  logic            load;
  logic [CH_W-1:0] ptr;
  logic [N_CH-1:0] gnt;
  logic [CH_W-1:0] gnt_idx;
  logic            any;
  logic [W-1:0]    ch_data [N_CH];
  arb_mode_e       mode;

  assign mode = arb_mode_e'(rr_en);

  for (genvar i = 0; i < N_CH; i++) begin : g_split
    assign ch_data[i] = in_data[i*W +: W];
  end

  rr_pick #(.N_CH(N_CH)) u_pick (
    .req     (in_valid),
    .ptr     (ptr),
    .rr_en   (rr_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // Register may refill in the same cycle it drains.
  assign load     = !out_valid || out_ready;
  assign in_ready = (load && !rst) ? gnt : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_valid <= any;
      if (any) begin
        out_data <= ch_data[gnt_idx];
        out_ch   <= gnt_idx;
        if (mode == ARB_RR) begin
          ptr <= (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised N-channel stream multiplexer with a registered output stage; the sequential successor of the 2:1 `mux` primitive.
- Selects one of `N_CH` valid/ready input streams per beat, using either round-robin or fixed-priority arbitration.
- Forwards the selected data plus its channel index to a single output stream.
- Sits between multiple producers and one shared consumer.

Parameters:
- N_CH, 4, number of input channels (>= 2)
- W, 8, data width per channel in bits
- CH_W, $clog2(N_CH), localparam; width of the channel index (not overridable)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- rr_en  input  1  1 = round-robin arbitration, 0 = fixed priority (lowest index wins)
- in_valid  input  N_CH  per-channel valid
- in_data  input  N_CH*W  channel i occupies bits [i*W +: W]
- in_ready  output  N_CH  per-channel ready; one-hot or zero
- out_valid  output  1  output register holds a beat
- out_data  output  W  data of held beat
- out_ch  output  CH_W  source channel of held beat
- out_ready  input  1  consumer accepts the beat

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0.
- While rst=1, in_ready=0 combinationally.
- Load condition: load = !out_valid || out_ready.
  - The output register may refill in the same cycle it drains. Full throughput is 1 beat/cycle.
- Grant, combinational:
  - If load=1 and |in_valid, pick channel g:
    - rr_en=1: first valid channel searching ptr, ptr+1, ..., N_CH-1, 0, ..., ptr-1 (wraps).
    - rr_en=0: lowest-index valid channel; ptr is ignored.
  - in_ready = one-hot(g) when load=1 and a grant exists; otherwise in_ready=0.
  - in_ready depends combinationally on in_valid and out_ready. Producers must not make in_valid depend on in_ready.
- Transfer on channel i when in_valid[i] && in_ready[i].
  - Next edge: out_valid<=1, out_data<=in_data[g], out_ch<=g.
- If load=1 and no channel is valid: out_valid<=0 next edge. out_data and out_ch keep their old values (don't-care).
- If load=0, i.e. out_valid=1 && out_ready=0:
  - out_valid, out_data and out_ch are held stable.
  - in_ready=0.
  - ptr is unchanged.
- Pointer update, only on a grant with rr_en=1: ptr <= (g == N_CH-1) ? 0 : g+1.
  - With rr_en=0, ptr holds its value.
  - Toggling rr_en mid-stream is legal and takes effect on the next grant.
- Latency: input handshake to out_valid is exactly 1 cycle.
- Reset mid-operation: any held beat is dropped, no in_ready is asserted in that cycle, and ptr returns to 0.
- No data loss or duplication: each input handshake produces exactly one output beat.
- A beat stays visible until an out_valid && out_ready handshake occurs.

Decomposition:
- No shared package is required. CH_W is a local localparam.
- Sub-module `rr_pick` (combinational), parameter N_CH:
  - inputs: req[N_CH], ptr[CH_W], rr_en
  - outputs: gnt one-hot[N_CH], gnt_idx[CH_W], any
  - Implement as a double-width request rotate plus priority encode.
- The top level holds the output register, ptr register, load logic and data select.
- Data select is an N:1 mux indexed by gnt_idx.

Test Plan (N_CH=4, W=8):
- Reset: hold rst=1 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=8'h00, out_ch=0, in_ready=4'b0000 throughout.
- Single channel: in_valid=4'b0100, ch2 data=8'hA5, out_ready=1 -> in_ready=4'b0100 in the same cycle; next cycle out_valid=1, out_data=8'hA5, out_ch=2.
- Round-robin fairness: rr_en=1, in_valid=4'b1111 constant, out_ready=1, data ch i = 8'h10+i -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles; out_data follows 8'h10..8'h13.
- Fixed priority and wrap:
  - rr_en=0, in_valid=4'b1111 -> out_ch=0 every beat; ch3 is never granted.
  - Then rr_en=1 with ptr=3 (set up by granting ch2) and in_valid=4'b0010 -> grant ch1, ptr becomes 2.
- Backpressure: out_valid=1 with out_data=8'h3C, then out_ready=0 for 3 cycles -> out_data=8'h3C and out_ch stable, in_ready=4'b0000. Raise out_ready -> a new input is accepted in that same cycle and appears on the next cycle.
- Reset mid-stream: after grants to ch0 and ch1, assert rst for 1 cycle with in_valid=4'b1111 -> out_valid=0 after the edge; the first grant after release is ch0.
